// File: rtl/ts_packet_generator.sv
// ts_packet_generator: emits 188-byte MPEG-TS packets (4-byte header followed by
// 184 payload bytes pulled from the pl_* stream) on a registered valid/ready
// byte stream.
// Build option: define CC_ERROR_INJECT_EN to let inject_cc_err make a packet
// advance the continuity counter by 2, which creates a deliberate CC skip.
`timescale 1ns/1ps
module ts_packet_generator #(
    parameter logic [12:0] PID = 13'h0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pusi,
    input  logic        inject_cc_err,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sync,
    input  logic        out_ready,
    output logic [15:0] pkt_count
);

    localparam logic [7:0] SYNC_BYTE = 8'h47;
    localparam logic [7:0] LAST_HDR  = 8'd3;
    localparam logic [7:0] LAST_IDX  = 8'd187;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  cc_q;
    logic [3:0]  cc_d;
    logic [15:0] pkt_count_q;
    logic        pusi_q;
    logic [7:0]  out_data_q;
    logic        out_valid_q;
    logic        out_sync_q;
    logic [7:0]  hdr_byte_d;
    logic        adv;
    logic        inject_d;

`ifdef CC_ERROR_INJECT_EN
    logic        inject_q;
    assign inject_d = inject_q;
`else
    // Port kept for a uniform interface; the request has no effect here.
    logic        unused_inject;
    assign unused_inject = inject_cc_err;
    assign inject_d      = 1'b0;
`endif

    // The output register may take a new byte whenever it is empty or being drained.
    assign adv       = !out_valid_q || out_ready;
    assign pl_ready  = (state_q == PAYLOAD) && adv;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sync  = out_sync_q;
    assign pkt_count = pkt_count_q;

    // Header byte selection and next continuity counter value.
    always_comb begin
        hdr_byte_d = SYNC_BYTE;
        case (cnt_q[1:0])
            2'd0:    hdr_byte_d = SYNC_BYTE;
            2'd1:    hdr_byte_d = {1'b0, pusi_q, 1'b0, PID[12:8]};
            2'd2:    hdr_byte_d = PID[7:0];
            default: hdr_byte_d = {2'b00, 2'b01, cc_q};
        endcase
        cc_d = inject_d ? (cc_q + 4'd2) : (cc_q + 4'd1);
    end

    // Packet FSM: sequences header and payload bytes into the registered output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            cc_q        <= 4'd0;
            pkt_count_q <= 16'd0;
            pusi_q      <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_sync_q  <= 1'b0;
`ifdef CC_ERROR_INJECT_EN
            inject_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (adv) begin
                        out_valid_q <= 1'b0;
                        out_sync_q  <= 1'b0;
                    end
                    if (enable) begin
                        state_q <= HEADER;
                        cnt_q   <= 8'd0;
                        pusi_q  <= pusi;
`ifdef CC_ERROR_INJECT_EN
                        inject_q <= inject_cc_err;
`endif
                    end
                end
                HEADER: begin
                    if (adv) begin
                        out_data_q  <= hdr_byte_d;
                        out_valid_q <= 1'b1;
                        out_sync_q  <= (cnt_q == 8'd0);
                        cnt_q       <= cnt_q + 8'd1;
                        if (cnt_q == LAST_HDR) begin
                            state_q <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (adv) begin
                        if (pl_valid) begin
                            out_data_q  <= pl_data;
                            out_valid_q <= 1'b1;
                            out_sync_q  <= 1'b0;
                            if (cnt_q == LAST_IDX) begin
                                // Packet boundary: the only place enable is sampled mid-stream.
                                cnt_q       <= 8'd0;
                                cc_q        <= cc_d;
                                pkt_count_q <= pkt_count_q + 16'd1;
                                if (enable) begin
                                    state_q <= HEADER;
                                    pusi_q  <= pusi;
`ifdef CC_ERROR_INJECT_EN
                                    inject_q <= inject_cc_err;
`endif
                                end else begin
                                    state_q <= IDLE;
                                end
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end else begin
                            // Stall without filler: let the output run dry.
                            out_valid_q <= 1'b0;
                            out_sync_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ts_packet_generator.sv
// tb_ts_packet_generator: directed bench for ts_packet_generator.
`timescale 1ns/1ps
module tb_ts_packet_generator;

    localparam int PKT = 188;
`ifdef CC_ERROR_INJECT_EN
    localparam logic [3:0] CC_AFTER_INJECT = 4'd4;
`else
    localparam logic [3:0] CC_AFTER_INJECT = 4'd3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        pusi;
    logic        inject_cc_err;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sync;
    logic        out_ready;
    logic [15:0] pkt_count;

    typedef struct {
        logic [7:0] data;
        logic       sync;
        int         cyc;
    } rec_t;

    rec_t       outq[$];
    int         cyc = 0;
    logic [7:0] pl_seq = 8'd0;
    logic       pl_take = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    ts_packet_generator #(.PID(13'h0100)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pusi         (pusi),
        .inject_cc_err(inject_cc_err),
        .pl_data      (pl_data),
        .pl_valid     (pl_valid),
        .pl_ready     (pl_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_sync     (out_sync),
        .out_ready    (out_ready),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    assign pl_data = pl_seq;

    // Record every byte that will transfer on the next rising edge.
    always @(negedge clk) begin
        rec_t r;
        if (rst && out_valid && out_ready) begin
            r.data = out_data;
            r.sync = out_sync;
            r.cyc  = cyc;
            outq.push_back(r);
        end
        pl_take = pl_valid && pl_ready;
    end

    // Cycle count and payload source: a new byte after each accepted one.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (pl_take) pl_seq = pl_seq + 8'd1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (outq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_reached"}, 32'(outq.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        outq.delete();
    endtask

    function automatic int count_gaps(input int from, input int to);
        int g;
        g = 0;
        for (int i = from + 1; i <= to && i < outq.size(); i++)
            if (outq[i].cyc != outq[i-1].cyc + 1) g++;
        return g;
    endfunction

    task automatic check_packet(input int base, input logic [3:0] exp_cc,
                                input logic [7:0] exp_b1, input string tag);
        int bad_seq;
        int bad_sync;
        bad_seq  = 0;
        bad_sync = 0;
        if (outq.size() < base + PKT) begin
            chk({tag, "_present"}, 32'(outq.size()), 32'(base + PKT));
        end else begin
            chk({tag, "_b0"},    32'(outq[base].data),   32'h47);
            chk({tag, "_sync0"}, 32'(outq[base].sync),   32'd1);
            chk({tag, "_b1"},    32'(outq[base+1].data), 32'(exp_b1));
            chk({tag, "_b2"},    32'(outq[base+2].data), 32'h00);
            chk({tag, "_b3cc"},  32'(outq[base+3].data), 32'({4'h1, exp_cc}));
            for (int i = 1; i < PKT; i++)
                if (outq[base+i].sync) bad_sync++;
            for (int i = 5; i < PKT; i++)
                if (outq[base+i].data != outq[base+i-1].data + 8'd1) bad_seq++;
            chk({tag, "_extra_sync"}, 32'(bad_sync), 32'd0);
            chk({tag, "_payload_seq"}, 32'(bad_seq), 32'd0);
        end
    endtask

    initial begin
        int start_cyc;
        int bad_hold;
        int lows;

        rst = 1'b0; enable = 1'b0; pusi = 1'b0; inject_cc_err = 1'b0;
        pl_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sync",  32'(out_sync),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_pl_ready",  32'(pl_ready),  32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);

        // Single packet, everything flowing
        rst = 1'b1;
        tick();
        outq.delete();
        enable = 1'b1; pl_valid = 1'b1;
        start_cyc = cyc;
        tick(); tick(); tick();
        enable = 1'b0;
        wait_bytes(PKT, 400, "t1");
        tick(); tick(); tick();
        chk("t1_size", 32'(outq.size()), 32'(PKT));
        if (outq.size() > 0) chk("t1_latency", 32'(outq[0].cyc - start_cyc), 32'd2);
        check_packet(0, 4'd0, 8'h01, "t1");
        chk("t1_gaps", 32'(count_gaps(0, PKT - 1)), 32'd0);
        chk("t1_pkt_count", 32'(pkt_count), 32'd1);
        chk("t1_idle_valid", 32'(out_valid), 32'd0);

        // 17 back-to-back packets, cc wraps
        do_reset();
        pusi = 1'b1; enable = 1'b1; pl_valid = 1'b1;
        wait_bytes(16 * PKT + 10, 4000, "t2_mid");
        enable = 1'b0;
        wait_bytes(17 * PKT, 400, "t2");
        tick(); tick(); tick();
        chk("t2_size", 32'(outq.size()), 32'(17 * PKT));
        for (int p = 0; p < 17; p++)
            check_packet(p * PKT, 4'(p % 16), 8'h41, $sformatf("t2_p%0d", p));
        chk("t2_gaps", 32'(count_gaps(0, 17 * PKT - 1)), 32'd0);
        chk("t2_pkt_count", 32'(pkt_count), 32'd17);

        // Output back-pressure on header byte 2
        do_reset();
        pusi = 1'b0; enable = 1'b1; pl_valid = 1'b1; out_ready = 1'b1;
        wait_bytes(2, 50, "t3_hdr");
        out_ready = 1'b0; enable = 1'b0;
        bad_hold = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_data !== 8'h00 || out_valid !== 1'b1 || pl_ready !== 1'b0) bad_hold++;
        end
        @(posedge clk);
        #1;
        chk("t3_held_data", 32'(out_data), 32'h00);
        chk("t3_hold_bad", 32'(bad_hold), 32'd0);
        out_ready = 1'b1;
        wait_bytes(PKT, 400, "t3");
        tick(); tick(); tick();
        chk("t3_size", 32'(outq.size()), 32'(PKT));
        check_packet(0, 4'd0, 8'h01, "t3");
        chk("t3_pkt_count", 32'(pkt_count), 32'd1);

        // Payload starvation after payload byte 50
        do_reset();
        enable = 1'b1; pl_valid = 1'b1;
        wait_bytes(54, 100, "t4_pl50");
        pl_valid = 1'b0; enable = 1'b0;
        lows = 0;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid) lows++;
        end
        @(posedge clk);
        #1;
        pl_valid = 1'b1;
        chk("t4_gap_lows", 32'(lows), 32'd9);
        wait_bytes(PKT, 400, "t4");
        tick(); tick(); tick();
        chk("t4_size", 32'(outq.size()), 32'(PKT));
        check_packet(0, 4'd0, 8'h01, "t4");
        chk("t4_gaps", 32'(count_gaps(0, PKT - 1)), 32'd1);
        chk("t4_pkt_count", 32'(pkt_count), 32'd1);

        // Continuity-error injection on packet 3
        do_reset();
        enable = 1'b1; pl_valid = 1'b1; inject_cc_err = 1'b0;
        wait_bytes(PKT + 10, 400, "t5_p2");
        inject_cc_err = 1'b1;
        wait_bytes(2 * PKT + 10, 400, "t5_p3");
        inject_cc_err = 1'b0;
        wait_bytes(3 * PKT + 10, 400, "t5_p4");
        enable = 1'b0;
        wait_bytes(4 * PKT, 400, "t5");
        tick(); tick(); tick();
        chk("t5_size", 32'(outq.size()), 32'(4 * PKT));
        check_packet(0,       4'd0, 8'h01, "t5_p1");
        check_packet(PKT,     4'd1, 8'h01, "t5_p2");
        check_packet(2 * PKT, 4'd2, 8'h01, "t5_p3");
        check_packet(3 * PKT, CC_AFTER_INJECT, 8'h01, "t5_p4");
        chk("t5_pkt_count", 32'(pkt_count), 32'd4);

        // Asynchronous reset in the middle of payload
        outq.delete();
        enable = 1'b1; pl_valid = 1'b1;
        wait_bytes(105, 400, "t6_pl100");
        enable = 1'b0;
        chk("t6_pre_count", 32'(pkt_count), 32'd4);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_sync",  32'(out_sync),  32'd0);
        chk("t6_out_data",  32'(out_data),  32'h00);
        chk("t6_pl_ready",  32'(pl_ready),  32'd0);
        chk("t6_pkt_count", 32'(pkt_count), 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();
        outq.delete();
        enable = 1'b1;
        tick(); tick(); tick();
        enable = 1'b0;
        wait_bytes(PKT, 400, "t6");
        tick(); tick(); tick();
        chk("t6_size", 32'(outq.size()), 32'(PKT));
        check_packet(0, 4'd0, 8'h01, "t6");
        chk("t6_post_count", 32'(pkt_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
